// File: rtl/arbiter_writer.sv
// Byte writer feeding one port of a shared-bus arbiter: a small FIFO of local
// bytes, a request FSM, a sticky busy-timeout flag and a delivered-byte counter.
module arbiter_writer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic        o_req,
  input  logic        i_busy,
  output logic [7:0]  o_data,
  input  logic        i_clr_timeout,
  output logic        o_timeout,
  output logic [15:0] o_sent
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = 16;
  localparam logic [BW-1:0] TO_MAX  = BW'(TIMEOUT);
  localparam logic [BW-1:0] TO_LAST = BW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    REQUEST = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_inc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [BW-1:0]   busy_cnt;

  logic            push_c;
  logic            pop_c;
  logic            set_to_c;
  logic [7:0]      data_next;
  logic [BW-1:0]   busy_cnt_next;
  logic            timeout_next;
  logic            ready_next;

  // Handshakes: push on local valid/ready, pop on arbiter grant (req & !busy).
  assign push_c     = i_valid & o_ready;
  assign pop_c      = (state == REQUEST) & ~i_busy;
  assign count_next = count + CW'(push_c) - CW'(pop_c);
  assign rd_ptr_inc = rd_ptr + AW'(1);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; REQUEST is only held while the queue is non-empty.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != CW'(0)) state_next = REQUEST;
      REQUEST: if (pop_c && (count_next == CW'(0))) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and the busy counter.
  always_comb begin
    data_next     = o_data;
    busy_cnt_next = '0;
    set_to_c      = 1'b0;
    timeout_next  = o_timeout;
    ready_next    = (count_next < CW'(DEPTH));

    if ((state == IDLE) && (count != CW'(0))) begin
      data_next = mem[rd_ptr];
    end else if (pop_c) begin
      // Next head is the second stored entry, or the byte pushed this cycle.
      if (count >= CW'(2)) begin
        data_next = mem[rd_ptr_inc];
      end else if (push_c) begin
        data_next = i_data;
      end
    end

    if ((state == REQUEST) && i_busy) begin
      busy_cnt_next = (busy_cnt == TO_MAX) ? busy_cnt : busy_cnt + BW'(1);
      set_to_c      = (busy_cnt == TO_LAST);
    end

    if (set_to_c) begin
      timeout_next = 1'b1;
    end else if (i_clr_timeout) begin
      timeout_next = 1'b0;
    end
  end

  // Queue storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (push_c) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      busy_cnt  <= '0;
      o_ready   <= 1'b1;
      o_req     <= 1'b0;
      o_data    <= 8'h00;
      o_timeout <= 1'b0;
      o_sent    <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr_inc;
      if (pop_c)  o_sent <= o_sent + BW'(1);
      count     <= count_next;
      busy_cnt  <= busy_cnt_next;
      o_ready   <= ready_next;
      o_req     <= (state_next == REQUEST);
      o_data    <= data_next;
      o_timeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_arbiter_writer.sv
// Directed bench for arbiter_writer: a default instance plus a TIMEOUT=8
// instance driven by the same stimulus.
module tb_arbiter_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid;
  logic [7:0]  data;
  logic        busy;
  logic        clr;

  logic        ready_a, req_a, to_a;
  logic [7:0]  data_a;
  logic [15:0] sent_a;
  logic        ready_b, req_b, to_b;
  logic [7:0]  data_b;
  logic [15:0] sent_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arbiter_writer #(.DEPTH(4), .TIMEOUT(255)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .i_data(data),
    .o_ready(ready_a), .o_req(req_a), .i_busy(busy), .o_data(data_a),
    .i_clr_timeout(clr), .o_timeout(to_a), .o_sent(sent_a)
  );

  arbiter_writer #(.DEPTH(4), .TIMEOUT(8)) dut_to (
    .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .i_data(data),
    .o_ready(ready_b), .o_req(req_b), .i_busy(busy), .o_data(data_b),
    .i_clr_timeout(clr), .o_timeout(to_b), .o_sent(sent_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid   = 1'b0;
    data    = 8'h00;
    busy    = 1'b0;
    clr     = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    valid   = 1'b0;
    data    = 8'h00;
    busy    = 1'b0;
    clr     = 1'b0;
    #2;
    do_reset();

    // Reset values
    check("rst_req",   32'(req_a),   32'd0);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_data",  32'(data_a),  32'h00);
    check("rst_sent",  32'(sent_a),  32'd0);
    check("rst_to",    32'(to_a),    32'd0);

    // Single byte, arbiter idle
    valid = 1'b1; data = 8'hA5;
    step();
    valid = 1'b0;
    check("single_req_low", 32'(req_a), 32'd0);
    step();
    check("single_req",  32'(req_a),  32'd1);
    check("single_data", 32'(data_a), 32'hA5);
    check("single_sent0", 32'(sent_a), 32'd0);
    step();
    check("single_done",  32'(req_a),  32'd0);
    check("single_sent",  32'(sent_a), 32'd1);
    check("single_hold",  32'(data_a), 32'hA5);
    step();
    check("idle_hold", 32'(data_a), 32'hA5);

    // Busy stall for 10 cycles
    do_reset();
    busy = 1'b1; valid = 1'b1; data = 8'h3C;
    step();
    valid = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      check("stall_req",  32'(req_a),  32'd1);
      check("stall_data", 32'(data_a), 32'h3C);
      step();
    end
    busy = 1'b0;
    check("stall_sent0", 32'(sent_a), 32'd0);
    step();
    check("stall_done", 32'(req_a),  32'd0);
    check("stall_sent", 32'(sent_a), 32'd1);
    check("stall_to",   32'(to_a),   32'd0);

    // Full queue: fifth byte dropped, first four delivered in order
    do_reset();
    busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      valid = 1'b1; data = 8'(i);
      step();
      if (i == 3) check("full_ready3", 32'(ready_a), 32'd1);
      if (i == 4) check("full_ready4", 32'(ready_a), 32'd0);
    end
    valid = 1'b0;
    check("full_ready5", 32'(ready_a), 32'd0);
    check("full_head",   32'(data_a),  32'h01);
    busy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("full_req",   32'(req_a),  32'd1);
      check("full_order", 32'(data_a), 32'(k));
      step();
    end
    check("full_done",   32'(req_a),   32'd0);
    check("full_sent",   32'(sent_a),  32'd4);
    check("full_ready",  32'(ready_a), 32'd1);

    // Timeout on the TIMEOUT=8 instance; clear coinciding with set loses
    do_reset();
    busy = 1'b1; valid = 1'b1; data = 8'h77;
    step();
    valid = 1'b0;
    step();
    check("to_req_start", 32'(req_b), 32'd1);
    for (int b = 1; b <= 12; b++) begin
      clr = (b == 8);
      step();
      check("to_flag", 32'(to_b),  (b >= 8) ? 32'd1 : 32'd0);
      check("to_req",  32'(req_b), 32'd1);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("to_cleared", 32'(to_b), 32'd0);
    step();
    check("to_no_reset", 32'(to_b),   32'd0);
    check("to_data",     32'(data_b), 32'h77);
    check("to_a_flag",   32'(to_a),   32'd0);
    busy = 1'b0;
    step();
    check("to_sent", 32'(sent_b), 32'd1);
    check("to_done", 32'(req_b),  32'd0);

    // Streaming 0..99 with arbiter always free
    do_reset();
    for (int i = 0; i < 100; i++) begin
      valid = 1'b1; data = 8'(i);
      step();
      if (i == 0) check("stream_first", 32'(req_a), 32'd0);
      else        check("stream", {23'd0, req_a, data_a}, {23'd0, 1'b1, 8'(i - 1)});
    end
    valid = 1'b0;
    step();
    check("stream_last", {23'd0, req_a, data_a}, {23'd0, 1'b1, 8'd99});
    step();
    check("stream_done", 32'(req_a),  32'd0);
    check("stream_sent", 32'(sent_a), 32'd100);

    // Reset mid-request
    do_reset();
    valid = 1'b1; data = 8'h99;
    step();
    valid = 1'b0;
    step();
    step();
    check("mid_pre_sent", 32'(sent_a), 32'd1);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; data = 8'(8'h11 * (i + 1));
      step();
    end
    valid = 1'b0;
    check("mid_req", 32'(req_a), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req",   32'(req_a),   32'd0);
    check("mid_rst_ready", 32'(ready_a), 32'd1);
    check("mid_rst_sent",  32'(sent_a),  32'd0);
    check("mid_rst_data",  32'(data_a),  32'h00);
    #3;
    reset_n = 1'b1;
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_req", 32'(req_a), 32'd0);
    end
    check("post_rst_sent", 32'(sent_a), 32'd0);
    valid = 1'b1; data = 8'h5A;
    step();
    valid = 1'b0;
    step();
    check("resume_req",  32'(req_a),  32'd1);
    check("resume_data", 32'(data_a), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
